// File: rtl/relin_tile_accumulator_if.sv
// relin_tile_accumulator_if: loader/consumer bus for the relin tile accumulator
interface relin_tile_accumulator_if #(
   parameter int RELIN_KEY_TILE_WIDTH = 8,
   parameter int RELIN_KEY_LENGTH     = 512,
   parameter int NUM_RELIN_KEYS       = 8,
   parameter int DATA_WIDTH           = 64
);
   logic                                                   start;
   logic                                                   c_sel;
   logic                                                   c1_or_c0;
   logic                                                   request_signal;
   logic                                                   tile_valid;
   logic [$clog2(RELIN_KEY_LENGTH):0]                      tile_address;
   logic [NUM_RELIN_KEYS*RELIN_KEY_TILE_WIDTH*DATA_WIDTH-1:0] relin_key;
   logic [NUM_RELIN_KEYS*RELIN_KEY_TILE_WIDTH*DATA_WIDTH-1:0] digit_tile;
   logic                                                   result_valid;
   logic                                                   result_ack;
   logic [$clog2(RELIN_KEY_LENGTH)-1:0]                    rd_addr;
   logic [DATA_WIDTH-1:0]                                  rd_data;
   logic                                                   error;
   modport master (
      output start, c_sel, tile_valid, tile_address, relin_key, digit_tile, result_ack, rd_addr,
      input  c1_or_c0, request_signal, result_valid, rd_data, error
   );
   modport slave (
      input  start, c_sel, tile_valid, tile_address, relin_key, digit_tile, result_ack, rd_addr,
      output c1_or_c0, request_signal, result_valid, rd_data, error
   );
endinterface

// File: rtl/relin_tile_accumulator.sv
// relin_tile_accumulator: modular multiply-accumulate of relin key tiles into a polynomial buffer
module relin_tile_accumulator #(
   parameter int                    RELIN_KEY_TILE_WIDTH = 8,
   parameter int                    RELIN_KEY_LENGTH     = 512,
   parameter int                    NUM_RELIN_KEYS       = 8,
   parameter int                    DATA_WIDTH           = 64,
   parameter logic [DATA_WIDTH-1:0] MODULUS              = 64'hFFFF_FFFF_0000_0001
) (
   input logic                     clk,
   input logic                     reset,
   relin_tile_accumulator_if.slave bus
);
   localparam int TW = RELIN_KEY_TILE_WIDTH;
   localparam int LEN = RELIN_KEY_LENGTH;
   localparam int NK = NUM_RELIN_KEYS;
   localparam int DW = DATA_WIDTH;
   localparam int AW = $clog2(LEN) + 1;
   localparam int RW = $clog2(LEN);
   localparam int SW = DW + $clog2(NK) + 1;
   localparam logic [AW-1:0] STEP = AW'(TW);
   localparam logic [AW-1:0] LAST = AW'(LEN - TW);
   localparam logic [2*DW-1:0] M2 = {{DW{1'b0}}, MODULUS};
   localparam logic [SW-1:0] MS = SW'(MODULUS);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t            state, next_state;
   logic [AW-1:0]     exp_addr;
   logic              accept, last_tile, start_ok;
   logic              c_q, err_q;
   logic [DW-1:0]     rd_q;
   logic              a_valid, b_valid;
   logic [RW-1:0]     a_addr, b_addr;
   logic [NK*TW*DW-1:0] a_key, a_dig;
   logic [DW-1:0]     p_d [NK][TW];
   logic [DW-1:0]     p_q [NK][TW];
   logic [SW-1:0]     acc [TW];
   logic [DW-1:0]     s [TW];
   logic [DW-1:0]     buffer [LEN];

   assign start_ok = state == IDLE && bus.start;
   assign accept = state == ACCUM && bus.tile_valid && bus.tile_address == exp_addr;
   assign last_tile = bus.tile_valid && bus.tile_address == LAST;
   assign bus.request_signal = state == ACCUM && !last_tile;
   assign bus.result_valid = state == DONE;
   assign bus.c1_or_c0 = c_q;
   assign bus.error = err_q;
   assign bus.rd_data = rd_q;

   // next-state: DRAIN holds until the input stage is empty, i.e. the last tile is being written
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:  next_state = bus.start ? ACCUM : IDLE;
         ACCUM: next_state = (accept && exp_addr == LAST) ? DRAIN : ACCUM;
         DRAIN: next_state = a_valid ? DRAIN : DONE;
         DONE:  next_state = bus.result_ack ? IDLE : DONE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next_state;

   // run control: c1/c0 capture, expected tile address, sticky error on any dropped tile
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         c_q <= 1'b0;
         exp_addr <= '0;
         err_q <= 1'b0;
      end else begin
         if (start_ok) begin
            c_q <= bus.c_sel;
            exp_addr <= '0;
         end else if (accept) exp_addr <= exp_addr + STEP;
         err_q <= (start_ok ? 1'b0 : err_q) | (bus.tile_valid && !accept);
      end

   // pipeline valids/addresses; reset kills any in-flight buffer write
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
         a_addr <= '0;
         b_addr <= '0;
      end else begin
         a_valid <= accept;
         a_addr <= bus.tile_address[RW-1:0];
         b_valid <= a_valid;
         b_addr <= a_addr;
      end

   // pipeline data: captured tile, then reduced products
   always_ff @(posedge clk) begin
      if (accept) begin
         a_key <= bus.relin_key;
         a_dig <= bus.digit_tile;
      end
      p_q <= p_d;
   end

   for (genvar i = 0; i < NK; i++) begin : g_key
      for (genvar j = 0; j < TW; j++) begin : g_lane
         assign p_d[i][j] = DW'(({{DW{1'b0}}, a_key[(i*TW+j)*DW +: DW]} *
                                 {{DW{1'b0}}, a_dig[(i*TW+j)*DW +: DW]}) % M2);
      end
   end

   // per-lane sum over keys, reduced once
   always_comb begin
      for (int j = 0; j < TW; j++) begin
         acc[j] = '0;
         for (int i = 0; i < NK; i++) acc[j] = acc[j] + SW'(p_q[i][j]);
         s[j] = DW'(acc[j] % MS);
      end
   end

   // polynomial buffer write of a completed tile
   always_ff @(posedge clk)
      if (b_valid)
         for (int j = 0; j < TW; j++) buffer[b_addr + RW'(j)] <= s[j];

   // registered read port
   always_ff @(posedge clk or posedge reset)
      if (reset) rd_q <= '0;
      else rd_q <= buffer[bus.rd_addr];
endmodule

// File: tb/tb_relin_tile_accumulator.sv
// tb_relin_tile_accumulator: directed checks of the relin tile accumulator (TILE=2, LENGTH=8, KEYS=2, MOD=17)
module tb_relin_tile_accumulator;
   localparam int TW = 2;
   localparam int LEN = 8;
   localparam int NK = 2;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   relin_tile_accumulator_if #(
      .RELIN_KEY_TILE_WIDTH(TW), .RELIN_KEY_LENGTH(LEN), .NUM_RELIN_KEYS(NK), .DATA_WIDTH(DW)
   ) bus ();

   relin_tile_accumulator #(
      .RELIN_KEY_TILE_WIDTH(TW), .RELIN_KEY_LENGTH(LEN), .NUM_RELIN_KEYS(NK), .DATA_WIDTH(DW),
      .MODULUS(16'd17)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_tile(input int k, input int d);
      for (int e = 0; e < NK * TW; e++) begin
         bus.relin_key[e*DW +: DW] = DW'(k);
         bus.digit_tile[e*DW +: DW] = DW'(d);
      end
   endtask

   task automatic send(input int addr);
      bus.tile_address = 4'(addr);
      bus.tile_valid = 1'b1;
      tick();
      bus.tile_valid = 1'b0;
   endtask

   task automatic do_start(input logic sel);
      bus.c_sel = sel;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.c_sel = 1'b0;
   endtask

   task automatic wait_done;
      int n = 0;
      while (!bus.result_valid && n < 20) begin
         tick();
         n++;
      end
      chk("done_timeout", 32'(bus.result_valid), 1);
   endtask

   task automatic read_chk(input string tag, input int addr, input int exp);
      bus.rd_addr = 3'(addr);
      tick();
      chk(tag, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic ack;
      bus.result_ack = 1'b1;
      tick();
      bus.result_ack = 1'b0;
   endtask

   initial begin
      int exp_d [8] = '{8, 8, 16, 16, 7, 7, 15, 15};
      bus.start = 1'b0;
      bus.c_sel = 1'b0;
      bus.tile_valid = 1'b0;
      bus.tile_address = '0;
      bus.relin_key = '0;
      bus.digit_tile = '0;
      bus.result_ack = 1'b0;
      bus.rd_addr = '0;
      #1 reset = 1'b1;
      #1;
      chk("rst_c1_or_c0", 32'(bus.c1_or_c0), 0);
      chk("rst_request", 32'(bus.request_signal), 0);
      chk("rst_result_valid", 32'(bus.result_valid), 0);
      chk("rst_rd_data", 32'(bus.rd_data), 0);
      chk("rst_error", 32'(bus.error), 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      // tile in IDLE is a protocol error
      send(0);
      chk("idle_tile_error", 32'(bus.error), 1);
      chk("idle_request", 32'(bus.request_signal), 0);
      // full polynomial, key 3 digit 5 -> 13
      do_start(1'b1);
      chk("a_request", 32'(bus.request_signal), 1);
      chk("a_c1_or_c0", 32'(bus.c1_or_c0), 1);
      chk("a_start_clears_err", 32'(bus.error), 0);
      set_tile(3, 5);
      for (int a = 0; a < 6; a += 2) begin
         bus.tile_address = 4'(a);
         bus.tile_valid = 1'b1;
         #1;
         chk("a_request_mid", 32'(bus.request_signal), 1);
         tick();
      end
      bus.tile_address = 4'd6;
      #1;
      chk("a_request_last", 32'(bus.request_signal), 0);
      tick();
      bus.tile_valid = 1'b0;
      chk("a_rv_t1", 32'(bus.result_valid), 0);
      chk("a_request_drain", 32'(bus.request_signal), 0);
      tick();
      chk("a_rv_t2", 32'(bus.result_valid), 0);
      tick();
      chk("a_rv_t3", 32'(bus.result_valid), 1);
      chk("a_request_done", 32'(bus.request_signal), 0);
      for (int k = 0; k < LEN; k++) read_chk("a_coef", k, 13);
      chk("a_c1_or_c0_done", 32'(bus.c1_or_c0), 1);
      chk("a_err_done", 32'(bus.error), 0);
      ack();
      chk("a_rv_after_ack", 32'(bus.result_valid), 0);
      // modular edge 16*16 with a misaligned tile in between
      do_start(1'b0);
      chk("b_c1_or_c0", 32'(bus.c1_or_c0), 0);
      set_tile(16, 16);
      send(0);
      set_tile(2, 2);
      send(4);
      chk("b_misalign_err", 32'(bus.error), 1);
      tick();
      tick();
      tick();
      read_chk("b_dropped", 4, 13);
      set_tile(16, 16);
      send(2);
      send(4);
      send(6);
      wait_done();
      for (int k = 0; k < LEN; k++) read_chk("b_coef", k, 2);
      chk("b_err_sticky", 32'(bus.error), 1);
      ack();
      // reset in the middle of a run
      do_start(1'b1);
      chk("c_start_clears_err", 32'(bus.error), 0);
      set_tile(1, 4);
      send(0);
      send(2);
      reset = 1'b1;
      #1;
      chk("c_rst_c1_or_c0", 32'(bus.c1_or_c0), 0);
      chk("c_rst_request", 32'(bus.request_signal), 0);
      chk("c_rst_rv", 32'(bus.result_valid), 0);
      chk("c_rst_error", 32'(bus.error), 0);
      chk("c_rst_rd_data", 32'(bus.rd_data), 0);
      tick();
      tick();
      chk("c_rst_rv_hold", 32'(bus.result_valid), 0);
      reset = 1'b0;
      read_chk("c_killed0", 0, 2);
      read_chk("c_killed2", 2, 2);
      // fresh run, tile k uses key k+1 digit 4 -> 8(k+1) mod 17
      do_start(1'b0);
      for (int k = 0; k < 4; k++) begin
         set_tile(k + 1, 4);
         send(2 * k);
      end
      wait_done();
      for (int k = 0; k < LEN; k++) read_chk("d_coef", k, exp_d[k]);
      chk("d_c1_or_c0", 32'(bus.c1_or_c0), 0);
      ack();
      chk("d_rv_after_ack", 32'(bus.result_valid), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
